// File: rtl/sipo_register.sv
// Serial-in parallel-out word assembler; word appears on dout 1 clk after its last bit; a word completing while unacked is dropped (overrun).
// Optional SIPO_PARITY_EN appends an even-parity bit per word and adds parity_err.
module sipo_register #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  input  logic             dout_ack,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef SIPO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sr_next, shifted, word;
  logic [CW-1:0]    count, count_next;
  logic             data_bit;
  logic             complete;
  logic             load;
  logic             perr_calc;

  assign complete = din_valid && (count == LAST);
  // A completed word only lands if the previous one is gone or is being acked now.
  assign load     = complete && (!dout_valid || dout_ack);
  assign busy     = (state == SHIFT);

  always_comb begin
    state_next = state;
    count_next = count;
    sr_next    = sr;
    shifted    = MSB_FIRST ? {sr[WIDTH-2:0], din} : {din, sr[WIDTH-1:1]};
`ifdef SIPO_PARITY_EN
    data_bit   = (count != CW'(WIDTH));
    perr_calc  = (^sr) ^ din;
`else
    data_bit   = 1'b1;
    perr_calc  = 1'b0;
`endif
    word       = data_bit ? shifted : sr;
    if (din_valid) begin
      if (data_bit) begin
        sr_next = shifted;
      end
      if (complete) begin
        count_next = '0;
        state_next = IDLE;
      end else begin
        count_next = count + 1'b1;
        state_next = SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      sr         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      count      <= '0;
      sr         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      sr    <= sr_next;
      if (load) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ack) begin
        dout_valid <= 1'b0;
      end
      if (complete && !load) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else if (clear) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= perr_calc;
    end else if (dout_valid && dout_ack) begin
      parity_err <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/sipo_register.md
SIPO_REGISTER -- requirements
Module: sipo_register

Interface
REQ-001 Parameter WIDTH SHALL default to 4 and set the word length in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST SHALL default to 0; 0 means the first serial bit lands in dout[0], 1 means it lands in dout[WIDTH-1].
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 din  input  1  SHALL carry the serial data bit.
REQ-006 din_valid  input  1  SHALL qualify din; a bit is accepted only on an edge where din_valid=1.
REQ-007 clear  input  1  SHALL be a synchronous abort/flush.
REQ-008 dout_ack  input  1  SHALL be the consumer acknowledge for the current word.
REQ-009 dout  output  WIDTH  SHALL hold the last delivered parallel word.
REQ-010 dout_valid  output  1  SHALL indicate that dout holds an unacknowledged word.
REQ-011 busy  output  1  SHALL be high while a partial word is held (bit count != 0).
REQ-012 overrun  output  1  SHALL be a sticky flag for a completed word that was dropped.

Function
REQ-013 States SHALL be IDLE (count=0) and SHIFT (count 1..N-1), where N=WIDTH, or WIDTH+1 with parity enabled.
- IDLE->SHIFT on the first accepted bit.
- SHIFT->IDLE on the Nth accepted bit.
REQ-014 With MSB_FIRST=0, each accepted bit SHALL shift right into bit WIDTH-1; with MSB_FIRST=1, each accepted bit SHALL shift left into bit 0.
REQ-015 An edge with din_valid=0 SHALL hold the shift register, count and state unchanged.
REQ-016 On the edge accepting the Nth bit, the complete word, including that bit, SHALL be loaded into dout.
- dout_valid SHALL be 1 in the following cycle, giving a latency of 1 clock.
REQ-017 dout SHALL stay stable until the next successful word load.
REQ-018 An edge with dout_valid=1 and dout_ack=1 SHALL clear dout_valid, unless a new word completes on the same edge.
REQ-019 If a word completes while dout_valid=1 and dout_ack=0:
- the new word SHALL be discarded;
- dout and dout_valid SHALL be unchanged;
- overrun SHALL be set;
- the count SHALL still return to 0.
REQ-020 If a word completes on the same edge as dout_ack=1, the new word SHALL load, dout_valid SHALL stay 1 and overrun SHALL NOT be set.
REQ-021 dout_ack while dout_valid=0 SHALL be ignored.
REQ-022 overrun SHALL clear only on reset or clear.
REQ-023 clear=1 SHALL zero the shift register, count, dout, dout_valid and overrun on the next edge, taking priority over din_valid and dout_ack.
REQ-024 The count SHALL wrap to 0 after the Nth bit; back-to-back words with no idle cycle SHALL be supported.

Reset
REQ-025 rst=0 SHALL immediately force the shift register, count, dout, dout_valid, busy and overrun to 0, independent of clk.
- The same applies to parity_err when present.
REQ-026 Deassertion of rst mid-word SHALL leave the block in IDLE, with the partial word lost.

Configuration
REQ-027 With SIPO_PARITY_EN defined:
- N SHALL be WIDTH+1, where the final serial bit is an even-parity bit;
- an output parity_err (1 bit) SHALL exist;
- parity_err SHALL be 1 when the XOR of all WIDTH data bits and the parity bit is 1;
- parity_err SHALL be loaded with dout and cleared together with dout_valid, clear or reset;
- the parity bit SHALL NOT appear in dout.
REQ-028 Without SIPO_PARITY_EN, parity_err SHALL NOT exist and N SHALL be WIDTH.

Verification (WIDTH=4)
REQ-029 Serial bits 1,0,1,1 with MSB_FIRST=0 -> dout=4'b1101 and dout_valid=1 one cycle after the 4th accepting edge.
REQ-030 The same bits with MSB_FIRST=1 -> dout=4'b1011.
REQ-031 Bits interleaved with din_valid=0 gaps -> the same dout as REQ-029; busy=1 from the 1st bit until the 4th bit.
REQ-032 Overrun and acknowledge ordering:
- A second word 0,0,0,1 sent with no ack -> dout stays 4'b1101 and overrun=1.
- The same second word with dout_ack=1 on its completing edge -> dout=4'b1000, dout_valid=1, overrun=0.
REQ-033 rst driven to 0 after 2 bits, then released -> all outputs 0 asynchronously; a following 4-bit word is received correctly.
REQ-034 SIPO_PARITY_EN data 1,0,1,1 -> parity bit 1 gives parity_err=0; parity bit 0 gives parity_err=1. dout=4'b1101 in both cases.
